// File: rtl/shift_left_2bit_pkg.sv
// rtl/shift_left_2bit_pkg.sv - shared datapath widths for branch/jump address shifting
package shift_left_2bit_pkg;

  localparam int DATA_W     = 32;
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/shift_left_2bit.sv
// rtl/shift_left_2bit.sv - fixed left shift by SHAMT with overflow report and optional register stage
module shift_left_2bit
  import shift_left_2bit_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SHAMT = WORD_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [SHAMT-1:0] lost_bits,
  output logic             ovf,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid
);

  assign out       = {in[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
  assign lost_bits = in[WIDTH-1 -: SHAMT];
  // Signed result is exact only if every discarded bit matches the new sign bit.
  assign ovf       = (lost_bits != {SHAMT{out[WIDTH-1]}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

endmodule

// File: tb/tb_shift_left_2bit.sv
// tb/tb_shift_left_2bit.sv - randomized self-checking bench for shift_left_2bit
module tb_shift_left_2bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] in;
  logic        in_valid;
  logic [31:0] out;
  logic [1:0]  lost_bits;
  logic        ovf;
  logic [31:0] out_q;
  logic        out_valid;

  int checks;
  int errors;

  logic [31:0] exp_q;
  logic        exp_v;

  shift_left_2bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .lost_bits (lost_bits),
    .ovf       (ovf),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: multiply by 4 in 32-bit arithmetic; overflow means the exact signed product
  // does not fit in a signed 32-bit word.
  function automatic logic [31:0] m_out(input logic [31:0] v);
    logic [31:0] r;
    r = v * 32'd4;
    return r;
  endfunction

  function automatic logic [1:0] m_lost(input logic [31:0] v);
    logic [31:0] r;
    r = v / 32'h4000_0000;
    return r[1:0];
  endfunction

  function automatic logic m_ovf(input logic [31:0] v);
    longint s;
    s = longint'($signed(v)) * 64'sd4;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic test_reset;
    rst_n    = 1'b0;
    in       = '0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_q !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_q=%h out_valid=%b, required 00000000/0", out_q, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '0;
    exp_v = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] vin  [6];
    logic [31:0] vout [6];
    logic [1:0]  vlost[6];
    logic        vovf [6];
    vin[0] = 32'hFFFF_FFFF; vout[0] = 32'hFFFF_FFFC; vlost[0] = 2'b11; vovf[0] = 1'b0;
    vin[1] = 32'hFF01_F001; vout[1] = 32'hFC07_C004; vlost[1] = 2'b11; vovf[1] = 1'b0;
    vin[2] = 32'h000F_000B; vout[2] = 32'h003C_002C; vlost[2] = 2'b00; vovf[2] = 1'b0;
    vin[3] = 32'h0004_0000; vout[3] = 32'h0010_0000; vlost[3] = 2'b00; vovf[3] = 1'b0;
    vin[4] = 32'h4000_0000; vout[4] = 32'h0000_0000; vlost[4] = 2'b01; vovf[4] = 1'b1;
    vin[5] = 32'h0000_0000; vout[5] = 32'h0000_0000; vlost[5] = 2'b00; vovf[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in = vin[i];
      #1;
      checks++;
      if (out !== vout[i] || lost_bits !== vlost[i] || ovf !== vovf[i]) begin
        errors++;
        $display("FAIL directed[%0d] in=%h: got out=%h lost=%b ovf=%b, required out=%h lost=%b ovf=%b",
                 i, vin[i], out, lost_bits, ovf, vout[i], vlost[i], vovf[i]);
      end
    end
  endtask

  task automatic test_random_comb;
    logic [31:0] v;
    for (int i = 0; i < 200; i++) begin
      v = $urandom;
      if (i % 4 == 0) v[31:29] = 3'(i / 4);
      in = v;
      #1;
      checks++;
      if (out !== m_out(v) || lost_bits !== m_lost(v) || ovf !== m_ovf(v)) begin
        errors++;
        $display("FAIL random_comb in=%h: got out=%h lost=%b ovf=%b, required out=%h lost=%b ovf=%b",
                 v, out, lost_bits, ovf, m_out(v), m_lost(v), m_ovf(v));
      end
    end
  endtask

  task automatic test_registered;
    logic [31:0] v;
    logic        vld;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      v   = $urandom;
      vld = ($urandom_range(0, 2) != 0);
      in       = v;
      in_valid = vld;
      @(posedge clk);
      exp_v = vld;
      if (vld) exp_q = m_out(v);
      #1;
      checks++;
      if (out_q !== exp_q || out_valid !== exp_v) begin
        errors++;
        $display("FAIL registered[%0d]: got out_q=%h out_valid=%b, required %h/%b",
                 i, out_q, out_valid, exp_q, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in       = 32'h0000_0003;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_q !== 32'h0000_000C || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load: got out_q=%h out_valid=%b, required 0000000C/1", out_q, out_valid);
    end
    @(negedge clk);
    in       = 32'h1234_5678;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_q !== 32'h0000_000C || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold: got out_q=%h out_valid=%b, required 0000000C/0", out_q, out_valid);
    end
    exp_q = 32'h0000_000C;
    exp_v = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    in       = 32'h1111_1111;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in = 32'h4000_0001;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_q !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got out_q=%h out_valid=%b, required 00000000/0", out_q, out_valid);
    end
    checks++;
    if (out !== m_out(32'h4000_0001) || ovf !== 1'b1) begin
      errors++;
      $display("FAIL comb_during_reset: got out=%h ovf=%b, required %h/1", out, ovf, m_out(32'h4000_0001));
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_q !== 32'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got out_q=%h out_valid=%b, required 00000000/0", out_q, out_valid);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in       = 32'h2000_0005;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_q !== 32'h8000_0014 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_after_reset: got out_q=%h out_valid=%b, required 80000014/1", out_q, out_valid);
    end
    exp_q = 32'h8000_0014;
    exp_v = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random_comb();
    test_registered();
    test_back_to_back();
    test_async_reset();
    test_registered();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
